// File: rtl/combo_lock_pkg.sv
// Shared definitions for the combination lock: FSM state encoding and a width helper.
package combo_lock_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    OPEN    = 3'd3,
    PROGRAM = 3'd4,
    LOCKOUT = 3'd5
  } lock_state_e;

  // clog2 that never returns 0, so a degenerate parameter still yields a 1-bit vector
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/combo_lock_core_lockout_timer.sv
// Down-counter that holds the lock closed after too many failed attempts.
module lockout_timer #(
  parameter int W = 27
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         count,
  output logic         done
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_value;
    end else if (count && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign done = (cnt_reg == '0);

endmodule

// File: rtl/combo_lock_core.sv
// Combination lock: digit entry, code check, failed-attempt lockout and code programming.
module combo_lock_core
  import combo_lock_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DIGIT_W        = 4,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 100000000,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] RESET_CODE = 16'h1234
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [DIGIT_W-1:0]                      digit_in,
  input  logic                                    enter,
  input  logic                                    clear,
  input  logic                                    lock,
  input  logic                                    prog,
  output logic                                    unlocked,
  output logic                                    locked_out,
  output logic                                    prog_mode,
  output logic [clog2_min1(NUM_DIGITS+1)-1:0]     digit_count,
  output logic [clog2_min1(MAX_FAILS+1)-1:0]      fails,
  output logic [2:0]                              state
);

  localparam int CODE_W = NUM_DIGITS * DIGIT_W;
  localparam int DC_W   = clog2_min1(NUM_DIGITS + 1);
  localparam int FAIL_W = clog2_min1(MAX_FAILS + 1);
  localparam int TW     = clog2_min1(LOCKOUT_CYCLES);

  localparam logic [DC_W-1:0]   DC_LAST   = DC_W'(NUM_DIGITS - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAILS);
  localparam logic [TW-1:0]     LOCK_LOAD = TW'(LOCKOUT_CYCLES - 1);

  lock_state_e        state_reg;
  logic [DC_W-1:0]    dc_reg;
  logic [FAIL_W-1:0]  fails_reg;
  logic [CODE_W-1:0]  entry_reg;
  logic [CODE_W-1:0]  entry_next;
  logic [CODE_W-1:0]  code_reg;
  logic               timer_load;
  logic               timer_done;

  // Slot 0 sits in the MSBs; the slot written is the one named by the current count.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
      assign entry_next[(NUM_DIGITS-1-gi)*DIGIT_W +: DIGIT_W] =
        (dc_reg == DC_W'(gi)) ? digit_in : entry_reg[(NUM_DIGITS-1-gi)*DIGIT_W +: DIGIT_W];
    end
  endgenerate

  assign timer_load = (state_reg == CHECK) && (entry_reg != code_reg) &&
                      (fails_reg == FAIL_MAX - 1'b1);

  lockout_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (LOCK_LOAD),
    .count      (state_reg == LOCKOUT),
    .done       (timer_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      dc_reg     <= '0;
      fails_reg  <= '0;
      entry_reg  <= '0;
      code_reg   <= RESET_CODE;
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
      prog_mode  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (enter && !clear) begin
            entry_reg <= entry_next;
            dc_reg    <= DC_W'(1);
            state_reg <= (NUM_DIGITS == 1) ? CHECK : ENTRY;
          end
        end
        ENTRY: begin
          if (clear) begin
            dc_reg    <= '0;
            state_reg <= IDLE;
          end else if (enter) begin
            entry_reg <= entry_next;
            dc_reg    <= dc_reg + 1'b1;
            if (dc_reg == DC_LAST) state_reg <= CHECK;
          end
        end
        CHECK: begin
          dc_reg <= '0;
          if (entry_reg == code_reg) begin
            state_reg <= OPEN;
            fails_reg <= '0;
            unlocked  <= 1'b1;
          end else if (fails_reg == FAIL_MAX - 1'b1) begin
            state_reg  <= LOCKOUT;
            fails_reg  <= FAIL_MAX;
            locked_out <= 1'b1;
          end else begin
            state_reg <= IDLE;
            fails_reg <= fails_reg + 1'b1;
          end
        end
        OPEN: begin
          if (lock) begin
            state_reg <= IDLE;
            unlocked  <= 1'b0;
          end else if (prog) begin
            state_reg <= PROGRAM;
            dc_reg    <= '0;
            prog_mode <= 1'b1;
          end
        end
        PROGRAM: begin
          if (clear) begin
            dc_reg    <= '0;
            state_reg <= OPEN;
            prog_mode <= 1'b0;
          end else if (enter) begin
            entry_reg <= entry_next;
            if (dc_reg == DC_LAST) begin
              code_reg  <= entry_next;
              dc_reg    <= '0;
              state_reg <= OPEN;
              prog_mode <= 1'b0;
            end else begin
              dc_reg <= dc_reg + 1'b1;
            end
          end
        end
        LOCKOUT: begin
          if (timer_done) begin
            state_reg  <= IDLE;
            fails_reg  <= '0;
            locked_out <= 1'b0;
          end
        end
        default: begin
          state_reg  <= IDLE;
          dc_reg     <= '0;
          unlocked   <= 1'b0;
          locked_out <= 1'b0;
          prog_mode  <= 1'b0;
        end
      endcase
    end
  end

  assign digit_count = dc_reg;
  assign fails       = fails_reg;
  assign state       = state_reg;

endmodule

// File: tb/tb_combo_lock_core.sv
// Scoreboard bench: driver steps a queue-based lock model and pushes per-cycle expectations.
module tb_combo_lock_core;

  localparam int ND = 4;
  localparam int MF = 3;
  localparam int LC = 8;
  localparam int S_IDLE = 0, S_ENTRY = 1, S_CHECK = 2, S_OPEN = 3, S_PROGRAM = 4, S_LOCKOUT = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] digit_in = '0;
  logic       enter = 1'b0, clear = 1'b0, lock = 1'b0, prog = 1'b0;
  logic       unlocked, locked_out, prog_mode;
  logic [2:0] digit_count;
  logic [1:0] fails;
  logic [2:0] state;

  always #5 clk = ~clk;

  combo_lock_core #(.LOCKOUT_CYCLES(LC)) dut (
    .clk         (clk),
    .reset       (reset),
    .digit_in    (digit_in),
    .enter       (enter),
    .clear       (clear),
    .lock        (lock),
    .prog        (prog),
    .unlocked    (unlocked),
    .locked_out  (locked_out),
    .prog_mode   (prog_mode),
    .digit_count (digit_count),
    .fails       (fails),
    .state       (state)
  );

  typedef struct {
    int u; int lo; int pm; int dc; int f; int st; int idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   step = 0;

  // Reference model: the lock as a phase, the digits typed so far, the stored code.
  int mode;
  int digits[$];
  int code[ND];
  int fails_m;
  int lock_left;

  task automatic model_reset();
    mode = S_IDLE;
    digits.delete();
    code = '{1, 2, 3, 4};
    fails_m = 0;
    lock_left = 0;
  endtask

  task automatic model_step(input bit e, input int d, input bit c, input bit l, input bit p);
    bit ok;
    case (mode)
      S_IDLE: if (e && !c) begin
        digits = {d};
        mode = (ND == 1) ? S_CHECK : S_ENTRY;
      end
      S_ENTRY: if (c) begin
        digits.delete();
        mode = S_IDLE;
      end else if (e) begin
        digits.push_back(d);
        if (digits.size() == ND) mode = S_CHECK;
      end
      S_CHECK: begin
        ok = (digits.size() == ND);
        for (int i = 0; i < ND; i++) if (ok && digits[i] != code[i]) ok = 0;
        digits.delete();
        if (ok) begin
          mode = S_OPEN;
          fails_m = 0;
        end else begin
          fails_m++;
          if (fails_m >= MF) begin
            fails_m = MF;
            mode = S_LOCKOUT;
            lock_left = LC;
          end else begin
            mode = S_IDLE;
          end
        end
      end
      S_OPEN: if (l) mode = S_IDLE;
      else if (p) begin
        mode = S_PROGRAM;
        digits.delete();
      end
      S_PROGRAM: if (c) begin
        digits.delete();
        mode = S_OPEN;
      end else if (e) begin
        digits.push_back(d);
        if (digits.size() == ND) begin
          for (int i = 0; i < ND; i++) code[i] = digits[i];
          digits.delete();
          mode = S_OPEN;
        end
      end
      default: begin
        lock_left--;
        if (lock_left == 0) begin
          mode = S_IDLE;
          fails_m = 0;
        end
      end
    endcase
  endtask

  function automatic exp_t snapshot(input int idx);
    exp_t e;
    e.u   = (mode == S_OPEN || mode == S_PROGRAM) ? 1 : 0;
    e.lo  = (mode == S_LOCKOUT) ? 1 : 0;
    e.pm  = (mode == S_PROGRAM) ? 1 : 0;
    e.dc  = digits.size();
    e.f   = fails_m;
    e.st  = mode;
    e.idx = idx;
    return e;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input int expv);
    n_checks++;
    if (act !== 32'(expv)) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, expv);
    end
  endtask

  task automatic check_all(input exp_t e);
    chk("unlocked",    e.idx, 32'(unlocked),    e.u);
    chk("locked_out",  e.idx, 32'(locked_out),  e.lo);
    chk("prog_mode",   e.idx, 32'(prog_mode),   e.pm);
    chk("digit_count", e.idx, 32'(digit_count), e.dc);
    chk("fails",       e.idx, 32'(fails),       e.f);
    chk("state",       e.idx, 32'(state),       e.st);
  endtask

  // Monitor: one expectation per clock edge, sampled just after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_all(mon_e);
      $display("step %0d: state=%0d dc=%0d fails=%0d unl=%0d lo=%0d pm=%0d",
               mon_e.idx, state, digit_count, fails, unlocked, locked_out, prog_mode);
    end
  end

  task automatic drive(input bit e, input int d, input bit c, input bit l, input bit p);
    @(negedge clk);
    enter = e; digit_in = 4'(d); clear = c; lock = l; prog = p;
    model_step(e, d, c, l, p);
    step++;
    exp_q.push_back(snapshot(step));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  task automatic enter_code(input int a, input int b, input int c, input int d);
    drive(1, a, 0, 0, 0);
    drive(1, b, 0, 0, 0);
    drive(1, c, 0, 0, 0);
    drive(1, d, 0, 0, 0);
  endtask

  task automatic unlock_current();
    enter_code(code[0], code[1], code[2], code[3]);
    idle(2);
  endtask

  // Reset is raised between edges and checked before the next edge arrives.
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    enter = 0; clear = 0; lock = 0; prog = 0;
    model_reset();
    step++;
    #1;
    check_all(snapshot(step));
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int r, d;
    model_reset();
    apply_reset();

    unlock_current();                      // 1,2,3,4 opens two cycles after the last enter
    drive(0, 0, 0, 1, 0);
    enter_code(1, 2, 3, 5);                // wrong code
    idle(2);

    apply_reset();
    for (int k = 0; k < 3; k++) begin
      enter_code(5, 5, 5, 5);
      idle(1);
    end
    for (int k = 0; k < LC; k++) drive(1, k, k[0], k[1], 1);
    idle(2);

    unlock_current();                      // reprogram to 9,8,7,6
    drive(0, 0, 0, 0, 1);
    enter_code(9, 8, 7, 6);
    drive(0, 0, 0, 1, 0);
    enter_code(1, 2, 3, 4);
    idle(2);
    enter_code(9, 8, 7, 6);
    idle(2);

    drive(0, 0, 0, 1, 0);                  // clear beats enter, lock beats prog
    drive(1, 1, 0, 0, 0);
    drive(1, 2, 0, 0, 0);
    drive(1, 3, 1, 0, 0);
    idle(1);
    unlock_current();
    drive(0, 0, 0, 1, 1);
    idle(1);

    unlock_current();                      // reset in the middle of programming
    drive(0, 0, 0, 0, 1);
    drive(1, 4, 0, 0, 0);
    drive(1, 4, 0, 0, 0);
    apply_reset();
    unlock_current();

    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 99);
      d = ($urandom_range(0, 3) != 0 && digits.size() < ND) ? code[digits.size()]
                                                            : int'($urandom_range(0, 15));
      if (r < 60)      drive(1, d, 0, 0, 0);
      else if (r < 67) drive(0, d, 1, 0, 0);
      else if (r < 74) drive(0, d, 0, 1, 0);
      else if (r < 82) drive(0, d, 0, 0, 1);
      else if (r < 85) drive(1, d, 1, 0, 0);
      else if (r < 88) drive(0, d, 0, 1, 1);
      else if (r < 89) apply_reset();
      else             drive(0, d, 0, 0, 0);
    end
    idle(2);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    chk("drain", step, 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/combo_lock_core.md
COMBO_LOCK_CORE -- requirements
Module: combo_lock_core

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports clk and reset.
REQ-002 Parameters (name, default, meaning):
- NUM_DIGITS, 4, digits per code.
- DIGIT_W, 4, bits per digit.
- MAX_FAILS, 3, consecutive wrong codes before lockout.
- LOCKOUT_CYCLES, 100000000, lockout duration in clk cycles.
- RESET_CODE, 16'h1234, code loaded at reset, NUM_DIGITS*DIGIT_W wide, first digit in the MSBs.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- digit_in, in, DIGIT_W, digit value sampled on enter.
- enter, in, 1, single-cycle pulse, already debounced upstream.
- clear, in, 1, single-cycle pulse that discards the partial entry.
- lock, in, 1, single-cycle pulse that relocks from OPEN.
- prog, in, 1, single-cycle pulse that starts code programming from OPEN.
- unlocked, out, 1, high in OPEN and PROGRAM.
- locked_out, out, 1, high in LOCKOUT.
- prog_mode, out, 1, high in PROGRAM.
- digit_count, out, clog2(NUM_DIGITS+1), digits captured so far.
- fails, out, clog2(MAX_FAILS+1), consecutive failed attempts.
- state, out, 3, encoded FSM state for debug and seven-segment display.

Function
REQ-004 The FSM SHALL have six states: IDLE, ENTRY, CHECK, OPEN, PROGRAM, LOCKOUT.
REQ-005 In IDLE, enter SHALL capture digit_in into entry slot 0, set digit_count to 1, and move to ENTRY.
REQ-006 In ENTRY, each enter SHALL capture into slot digit_count and increment digit_count. When digit_count reaches NUM_DIGITS the FSM SHALL move to CHECK on the next edge.
REQ-007 CHECK SHALL last exactly one cycle and compare all digits against the stored code, with these outcomes:
- Match: go to OPEN and clear fails.
- Mismatch with fails+1 < MAX_FAILS: go to IDLE and increment fails.
- Mismatch with fails+1 = MAX_FAILS: go to LOCKOUT and set fails to MAX_FAILS.
REQ-008 Latency from the final enter pulse to unlocked=1 SHALL be exactly 2 clk cycles.
REQ-009 LOCKOUT SHALL load a down-counter with LOCKOUT_CYCLES-1 and decrement it each cycle. At zero it SHALL go to IDLE and clear fails. enter, clear, lock and prog SHALL be ignored in LOCKOUT.
REQ-010 In OPEN, lock SHALL go to IDLE and prog SHALL go to PROGRAM with digit_count=0. If both pulse in the same cycle, lock SHALL win.
REQ-011 In PROGRAM, each enter SHALL capture a digit as in REQ-006. After NUM_DIGITS digits the new code SHALL be written to the code register in a single cycle and the FSM SHALL return to OPEN.
REQ-012 clear SHALL zero digit_count. In ENTRY it SHALL go to IDLE; in PROGRAM it SHALL go to OPEN with the stored code unchanged. clear SHALL win over enter in the same cycle. clear SHALL NOT change fails.
REQ-013 enter in CHECK SHALL be ignored.
REQ-014 digit_count SHALL never exceed NUM_DIGITS. It SHALL be 0 in IDLE, OPEN and LOCKOUT.
REQ-015 All outputs SHALL be registered or decoded only from registered state.

Reset
REQ-016 Reset SHALL be asserted asynchronously at any time, including mid-entry, mid-program and mid-lockout.
REQ-017 On reset the block SHALL set:
- state to IDLE;
- digit_count, fails and the lockout counter to 0;
- the entry buffer to 0;
- the code register to RESET_CODE;
- unlocked, locked_out and prog_mode to 0.

Structure
REQ-018 Package combo_lock_pkg SHALL hold the state enumeration and its 3-bit encoding: IDLE=0, ENTRY=1, CHECK=2, OPEN=3, PROGRAM=4, LOCKOUT=5.
REQ-019 The lockout timer SHALL be a sub-module named lockout_timer, with a load/count/done interface and a parametrised width of clog2(LOCKOUT_CYCLES).
REQ-020 The code register and entry buffer SHALL be flat NUM_DIGITS*DIGIT_W vectors.

Verification
The bench SHALL use the defaults except LOCKOUT_CYCLES=8.
REQ-021 Correct code: reset, then enter 1,2,3,4 → unlocked=1 exactly 2 cycles after the 4th enter, and fails=0.
REQ-022 Wrong code: enter 1,2,3,5 → state returns to IDLE, fails=1, unlocked=0.
REQ-023 Lockout: three wrong codes → locked_out=1 and enter is ignored for 8 cycles; then state is IDLE and fails=0.
REQ-024 Programming: unlock, then prog, enter 9,8,7,6, then lock → code 1,2,3,4 fails and code 9,8,7,6 unlocks.
REQ-025 Clear precedence:
- Enter 1,2, then clear and enter in the same cycle → digit_count=0 and state is IDLE.
- In OPEN, lock and prog in the same cycle → state is IDLE.
REQ-026 Reset mid-program: reset asserted after prog plus 2 digits → state is IDLE and RESET_CODE (1,2,3,4) unlocks again.
